sky130_fd_io__amux_break_make_seq: RTL and testbench
====================================================

SKY130_FD_IO__AMUX_BREAK_MAKE_SEQ -- requirements
Module: sky130_fd_io__amux_break_make_seq

Interface
REQ-001 Parameter BREAK_CYC, default 4: cycles both switches are held open before any make; legal range 1..255.
REQ-002 Parameter SETTLE_CYC, default 2: cycles after a make before DONE is reported; legal range 0..255.
REQ-003 Port CLK, input, 1: sole clock; all state changes on the rising edge.
REQ-004 Port RESET, input, 1: synchronous, active-high reset.
REQ-005 Port REQ_VALID, input, 1: a new selection request is presented.
REQ-006 Port REQ_SEL, input, 2: requested selection; 00 = none, 01 = AMUXBUS_A, 10 = AMUXBUS_B, 11 = illegal.
REQ-007 Port REQ_READY, output, 1: the sequencer accepts a request this cycle.
REQ-008 Port PWR_GOOD, input, 1: IO supplies valid; low forces the bus open.
REQ-009 Port EN_A, output, 1: pad-to-AMUXBUS_A switch enable.
REQ-010 Port EN_B, output, 1: pad-to-AMUXBUS_B switch enable.
REQ-011 Port GND_CLAMP, output, 1: pad-side bus discharge clamp to the ground pad.
REQ-012 Port BUSY, output, 1: a sequence is in progress.
REQ-013 Port DONE, output, 1: one-cycle pulse when the requested selection is stable.
REQ-014 Port ERR, output, 1: sticky flag for an illegal request; cleared only by reset.

Function
REQ-015 States: IDLE, BREAK, MAKE, SETTLE; the state is encoded in registers.
REQ-016 REQ_READY SHALL be 1 only in IDLE with PWR_GOOD=1.
- A request is accepted when REQ_VALID and REQ_READY are both 1 on a rising edge.
- On acceptance, REQ_SEL is latched into cur_sel.
REQ-017 An accepted REQ_SEL=11 SHALL:
- set ERR;
- leave EN_A, EN_B and the state unchanged;
- not pulse DONE.
REQ-018 An accepted legal request SHALL:
- move IDLE to BREAK;
- clear EN_A and EN_B in that same edge;
- load the counter with BREAK_CYC-1.
REQ-019 BREAK SHALL:
- decrement the counter each cycle;
- at zero, go to MAKE.
- EN_A and EN_B are both 0 for exactly BREAK_CYC cycles.
REQ-020 MAKE SHALL:
- last one cycle;
- drive EN_A = (cur_sel==01) and EN_B = (cur_sel==10) from the next edge;
- load the counter with SETTLE_CYC.
REQ-021 SETTLE SHALL count down to zero, then pulse DONE for one cycle and return to IDLE.
- With SETTLE_CYC=0, DONE is asserted on the edge leaving MAKE.
REQ-022 Request to DONE latency SHALL be BREAK_CYC + SETTLE_CYC + 2 cycles.
REQ-023 EN_A and EN_B SHALL never be 1 in the same cycle, under any input sequence.
REQ-024 A request equal to the current selection SHALL still run the full break/make sequence.
REQ-025 REQ_SEL=00 SHALL run the sequence and end with both enables 0.
REQ-026 BUSY SHALL be 1 in BREAK, MAKE and SETTLE, and 0 in IDLE.
REQ-027 REQ_VALID while BUSY SHALL be ignored; there is no queueing and no error.
REQ-028 PWR_GOOD=0 sampled in any state SHALL, on that edge:
- clear EN_A and EN_B;
- go to IDLE;
- not pulse DONE;
- set cur_sel=00.
REQ-029 PWR_GOOD=0 coincident with an accepted request SHALL cause the request to be dropped.

Reset
REQ-030 RESET=1 sampled on an edge SHALL force:
- state=IDLE, counter=0, cur_sel=00;
- EN_A=0, EN_B=0, GND_CLAMP=0;
- BUSY=0, DONE=0, ERR=0.
REQ-031 RESET SHALL take priority over PWR_GOOD and REQ_VALID, including mid-sequence.
REQ-032 REQ_READY SHALL be 0 during any cycle in which RESET=1.

Configuration
REQ-033 Macro SKY130_FD_IO_AMUX_GND_CLAMP_EN: when defined, GND_CLAMP SHALL be 1 exactly in BREAK cycles and 0 otherwise.
- It is a registered output, aligned with the enables.
- The clamp is never 1 while EN_A or EN_B is 1.
REQ-034 When SKY130_FD_IO_AMUX_GND_CLAMP_EN is undefined, GND_CLAMP SHALL be tied 0 and all other behaviour is unchanged.

Verification
REQ-035 Reset, then REQ_SEL=01 request (defaults) -> BREAK 4 cycles, then EN_A=1 / EN_B=0, then DONE pulse 8 cycles after acceptance.
REQ-036 Hold A, then request REQ_SEL=10 -> EN_A falls at acceptance, both 0 for 4 cycles, then EN_B=1; never both 1.
REQ-037 Request REQ_SEL=11 -> ERR=1 sticky, enables unchanged, no DONE, REQ_READY stays 1.
REQ-038 PWR_GOOD low during SETTLE -> enables 0 next edge, IDLE, no DONE, REQ_READY=0 until PWR_GOOD=1.
REQ-039 RESET asserted in the 2nd BREAK cycle -> all outputs 0 the next edge; a subsequent request restarts the full sequence.
REQ-040 With the macro defined -> GND_CLAMP=1 for exactly the 4 BREAK cycles; without the macro -> GND_CLAMP=0 throughout.

Source files
------------

// File: rtl/sky130_fd_io__amux_break_make_seq.sv
// -----------------------------------------------------------------------------
// sky130_fd_io__amux_break_make_seq
//
// Break-before-make sequencer for the pad-to-AMUXBUS analog switches. A
// selection request first opens both switches for BREAK_CYC cycles, then makes
// the requested connection. After a further SETTLE_CYC cycles it returns to
// idle and pulses DONE. Losing PWR_GOOD opens the bus immediately.
//
// Optional feature macro: SKY130_FD_IO_AMUX_GND_CLAMP_EN
//   defined   -> GND_CLAMP is 1 exactly during the BREAK cycles
//   undefined -> GND_CLAMP is tied 0
//
// Parameters
//   BREAK_CYC  (1..255) cycles both switches are held open before a make
//   SETTLE_CYC (0..255) cycles after a make before DONE is reported
//
// Ports
//   CLK        in   sole clock, rising edge
//   RESET      in   synchronous active-high reset
//   REQ_VALID  in   selection request presented
//   REQ_SEL    in   [1:0] 00 none, 01 AMUXBUS_A, 10 AMUXBUS_B, 11 illegal
//   REQ_READY  out  request accepted this cycle if REQ_VALID is also 1
//   PWR_GOOD   in   IO supplies valid; low forces the bus open
//   EN_A       out  pad-to-AMUXBUS_A switch enable (registered)
//   EN_B       out  pad-to-AMUXBUS_B switch enable (registered)
//   GND_CLAMP  out  pad-side bus discharge clamp (registered)
//   BUSY       out  sequence in progress (BREAK, MAKE or SETTLE)
//   DONE       out  one-cycle pulse when the selection is stable (registered)
//   ERR        out  sticky illegal-request flag, cleared only by RESET
//   DBG_STATE  out  [1:0] current FSM state (0 IDLE, 1 BREAK, 2 MAKE, 3 SETTLE)
//
// Handshake: a request transfers on a rising edge where REQ_VALID and
// REQ_READY are both 1. REQ_READY depends only on state, PWR_GOOD and RESET,
// never on REQ_VALID. A request presented while not ready is dropped; there
// is no queueing.
// -----------------------------------------------------------------------------
module sky130_fd_io__amux_break_make_seq #(
  parameter int unsigned BREAK_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_SEL,
  output logic       REQ_READY,
  input  logic       PWR_GOOD,
  output logic       EN_A,
  output logic       EN_B,
  output logic       GND_CLAMP,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BREAK  = 2'd1,
    S_MAKE   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

`ifdef SKY130_FD_IO_AMUX_GND_CLAMP_EN
  localparam logic CLAMP_EN = 1'b1;
`else
  localparam logic CLAMP_EN = 1'b0;
`endif

  localparam logic [7:0] BREAK_LOAD  = 8'(BREAK_CYC - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_cur_sel;
  logic       r_en_a;
  logic       r_en_b;
  logic       r_clamp;
  logic       r_done;
  logic       r_err;

  logic       w_ready;
  logic       w_accept;

  assign w_ready  = (r_state == S_IDLE) && PWR_GOOD && !RESET;
  assign w_accept = REQ_VALID && w_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_cur_sel <= 2'b00;
      r_en_a    <= 1'b0;
      r_en_b    <= 1'b0;
      r_clamp   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!PWR_GOOD) begin
        // Supply loss overrides everything short of reset, including a
        // request presented on the same edge.
        r_state   <= S_IDLE;
        r_cnt     <= 8'd0;
        r_cur_sel <= 2'b00;
        r_en_a    <= 1'b0;
        r_en_b    <= 1'b0;
        r_clamp   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              if (REQ_SEL == 2'b11) begin
                // Illegal selection: flag it, but leave the switches alone.
                r_err <= 1'b1;
              end else begin
                r_cur_sel <= REQ_SEL;
                r_state   <= S_BREAK;
                r_cnt     <= BREAK_LOAD;
                r_en_a    <= 1'b0;
                r_en_b    <= 1'b0;
                r_clamp   <= CLAMP_EN;
              end
            end
          end
          S_BREAK: begin
            if (r_cnt == 8'd0) begin
              // Make on the edge leaving BREAK so the open window is exactly
              // BREAK_CYC cycles and the clamp releases as the switch closes.
              r_state <= S_MAKE;
              r_en_a  <= (r_cur_sel == 2'b01);
              r_en_b  <= (r_cur_sel == 2'b10);
              r_clamp <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_MAKE: begin
            if (SETTLE_CYC == 0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
              r_cnt   <= SETTLE_LOAD;
            end
          end
          S_SETTLE: begin
            if (r_cnt == 8'd0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign REQ_READY = w_ready;
  assign EN_A      = r_en_a;
  assign EN_B      = r_en_b;
  assign GND_CLAMP = r_clamp;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_sky130_fd_io__amux_break_make_seq.sv
// -----------------------------------------------------------------------------
// Directed testbench for sky130_fd_io__amux_break_make_seq (default parameters
// BREAK_CYC=4, SETTLE_CYC=2). Inputs are driven and outputs sampled 1 ns after
// each rising edge. Expected per-cycle output vectors for a full sequence are
// written out by hand from the timing of the block: four open cycles, make,
// three settle cycles, then DONE eight edges after acceptance.
// Vector layout: {REQ_READY, BUSY, DONE, EN_A, EN_B, GND_CLAMP}.
// -----------------------------------------------------------------------------
module tb_sky130_fd_io__amux_break_make_seq;

  localparam int W = 6;

`ifdef SKY130_FD_IO_AMUX_GND_CLAMP_EN
  localparam logic CLAMP_EXP = 1'b1;
`else
  localparam logic CLAMP_EXP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       pwr_good;
  logic       en_a;
  logic       en_b;
  logic       gnd_clamp;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  sky130_fd_io__amux_break_make_seq dut (
    .CLK       (clk),
    .RESET     (reset),
    .REQ_VALID (req_valid),
    .REQ_SEL   (req_sel),
    .REQ_READY (req_ready),
    .PWR_GOOD  (pwr_good),
    .EN_A      (en_a),
    .EN_B      (en_b),
    .GND_CLAMP (gnd_clamp),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err),
    .DBG_STATE (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle expectation for a legal request accepted on edge k=0.
  function automatic void build_exp(input logic [1:0] sel);
    logic ea, eb;
    ea = (sel == 2'b01);
    eb = (sel == 2'b10);
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      if (k <= 3)      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CLAMP_EXP});
      else if (k <= 7) exp_q.push_back({1'b0, 1'b1, 1'b0, ea, eb, 1'b0});
      else if (k == 8) exp_q.push_back({1'b1, 1'b0, 1'b1, ea, eb, 1'b0});
      else             exp_q.push_back({1'b1, 1'b0, 1'b0, ea, eb, 1'b0});
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; pwr_good = 1'b1; req_valid = 1'b0; req_sel = 2'b00;
    step(); step();
    n_checks++;
    if ({req_ready, busy, done, en_a, en_b, gnd_clamp, err, dbg_state} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {req_ready, busy, done, en_a, en_b, gnd_clamp, err, dbg_state}, 9'b0);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_select_a();
    logic [W-1:0] got, expv;
    build_exp(2'b01);
    req_valid = 1'b1; req_sel = 2'b01;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
      got = {req_ready, busy, done, en_a, en_b, gnd_clamp};
      expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL select_a k=%0d got=%b exp=%b", k, got, expv);
      end
    end
  endtask

  task automatic test_switch_b();
    logic [W-1:0] got, expv;
    n_checks++;
    if (en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_b_hold_a got=%b exp=1", en_a);
    end
    build_exp(2'b10);
    req_valid = 1'b1; req_sel = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
      got = {req_ready, busy, done, en_a, en_b, gnd_clamp};
      expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv || (en_a && en_b)) begin
        n_fail++;
        $display("FAIL switch_b k=%0d got=%b exp=%b", k, got, expv);
      end
    end
  endtask

  task automatic test_illegal();
    req_valid = 1'b1; req_sel = 2'b11;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({err, en_a, en_b, done, busy, req_ready, dbg_state} !== 8'b10100100) begin
        n_fail++;
        $display("FAIL illegal k=%0d got=%b exp=%b", k,
                 {err, en_a, en_b, done, busy, req_ready, dbg_state}, 8'b10100100);
      end
      step();
    end
  endtask

  task automatic test_same_sel();
    logic [W-1:0] got, expv;
    build_exp(2'b10);
    req_valid = 1'b1; req_sel = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
      got = {req_ready, busy, done, en_a, en_b, gnd_clamp};
      expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL same_sel k=%0d got=%b exp=%b", k, got, expv);
      end
    end
  endtask

  task automatic test_sel_none();
    logic [W-1:0] got, expv;
    build_exp(2'b00);
    req_valid = 1'b1; req_sel = 2'b00;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
      got = {req_ready, busy, done, en_a, en_b, gnd_clamp};
      expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL sel_none k=%0d got=%b exp=%b", k, got, expv);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] got, expv;
    build_exp(2'b01);
    req_valid = 1'b1; req_sel = 2'b01;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
      if (k == 2) begin req_valid = 1'b1; req_sel = 2'b10; end
      if (k == 3) req_valid = 1'b0;
      got = {req_ready, busy, done, en_a, en_b, gnd_clamp};
      expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, got, expv);
      end
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
  endtask

  task automatic test_pwr_drop();
    req_valid = 1'b1; req_sel = 2'b10;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
    end
    // k=5: first SETTLE cycle with EN_B made
    n_checks++;
    if ({dbg_state, en_b} !== 3'b111) begin
      n_fail++;
      $display("FAIL pwr_pre_settle got=%b exp=111", {dbg_state, en_b});
    end
    pwr_good = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if ({en_a, en_b, busy, done, req_ready, gnd_clamp, dbg_state} !== 8'b0) begin
        n_fail++;
        $display("FAIL pwr_drop k=%0d got=%b exp=%b", k,
                 {en_a, en_b, busy, done, req_ready, gnd_clamp, dbg_state}, 8'b0);
      end
    end
    pwr_good = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pwr_restore_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_pwr_with_req();
    pwr_good = 1'b0; req_valid = 1'b1; req_sel = 2'b01;
    step();
    req_valid = 1'b0; pwr_good = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({busy, en_a, en_b, done, dbg_state} !== 6'b0) begin
        n_fail++;
        $display("FAIL pwr_with_req k=%0d got=%b exp=%b", k,
                 {busy, en_a, en_b, done, dbg_state}, 6'b0);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_break();
    logic [W-1:0] got, expv;
    req_valid = 1'b1; req_sel = 2'b10;
    step();            // k=0, first BREAK cycle
    req_valid = 1'b0;
    step();            // k=1, second BREAK cycle
    reset = 1'b1; req_valid = 1'b1; req_sel = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_reset got=%b exp=0", req_ready);
    end
    step();
    n_checks++;
    if ({req_ready, busy, done, en_a, en_b, gnd_clamp, err, dbg_state} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_mid_break got=%b exp=%b",
               {req_ready, busy, done, en_a, en_b, gnd_clamp, err, dbg_state}, 9'b0);
    end
    // Restart: the still-asserted request is accepted once reset drops.
    reset = 1'b0;
    build_exp(2'b01);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) req_valid = 1'b0;
      got = {req_ready, busy, done, en_a, en_b, gnd_clamp};
      expv = exp_q.pop_front();
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL restart k=%0d got=%b exp=%b", k, got, expv);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; pwr_good = 1'b1; req_valid = 1'b0; req_sel = 2'b00;
    test_reset();
    test_select_a();
    test_switch_b();
    test_illegal();
    test_same_sel();
    test_sel_none();
    test_ignore_busy();
    test_pwr_drop();
    test_pwr_with_req();
    test_reset_mid_break();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
